// File: rtl/rmt_pkg.sv
// ---------------------------------------------------------------------------
// rmt_pkg
// Shared definitions for the ingress classifier: protocol constants, header
// byte offsets within the first two 256b beats, packet class and FSM state
// encodings, and a big-endian 16-bit field extractor.
// No ports (package).
// ---------------------------------------------------------------------------
package rmt_pkg;

    localparam logic [15:0] ETH_VLAN     = 16'h8100;
    localparam logic [15:0] ETH_IPV4     = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP = 8'h11;

    // Byte offsets: beat 1 carries L2/L3 headers, beat 2 the UDP header (IHL=5)
    localparam int unsigned OFS_ETHTYPE  = 12;
    localparam int unsigned OFS_INNER_ET = 16;
    localparam int unsigned OFS_PROTO    = 27;
    localparam int unsigned OFS_DPORT    = 8;

    typedef enum logic [1:0] {
        CLS_DATA,
        CLS_CTRL,
        CLS_DROP
    } pkt_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET2,
        ST_EMIT1,
        ST_EMIT2,
        ST_PASS_D,
        ST_PASS_C,
        ST_DROP
    } clf_state_e;

    // Byte 0 is d[7:0]; field bytes are big-endian on the wire
    function automatic logic [15:0] be16(input logic [255:0] d, input int unsigned ofs);
        return {d[8*ofs +: 8], d[8*(ofs+1) +: 8]};
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// ---------------------------------------------------------------------------
// axis_out_reg
// One-entry registered AXI-Stream output stage with downstream ready.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   load_i                 offer a beat (taken only when can_load_o)
//   data_i/user_i/keep_i/last_i  beat payload
//   ready_i                downstream tready
//   can_load_o             register is empty or draining this cycle
//   tdata_o/tuser_o/tkeep_o/tvalid_o/tlast_o  registered stream
// ---------------------------------------------------------------------------
module axis_out_reg #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned USER_W = 128
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [USER_W-1:0]   user_i,
    input  logic [DATA_W/8-1:0] keep_i,
    input  logic                last_i,
    input  logic                ready_i,
    output logic                can_load_o,
    output logic [DATA_W-1:0]   tdata_o,
    output logic [USER_W-1:0]   tuser_o,
    output logic [DATA_W/8-1:0] tkeep_o,
    output logic                tvalid_o,
    output logic                tlast_o
);

    logic                valid_q;
    logic [DATA_W-1:0]   data_q;
    logic [USER_W-1:0]   user_q;
    logic [DATA_W/8-1:0] keep_q;
    logic                last_q;

    assign can_load_o = !valid_q || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i && can_load_o) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            user_q  <= user_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign tdata_o  = data_q;
    assign tuser_o  = user_q;
    assign tkeep_o  = keep_q;
    assign tvalid_o = valid_q;
    assign tlast_o  = last_q;

endmodule

// File: rtl/ingress_pkt_classifier.sv
// ---------------------------------------------------------------------------
// ingress_pkt_classifier
// Holds the first two beats of each ingress packet, classifies it as
// CTRL (VLAN/IPv4/UDP to CTRL_UDP_PORT), DATA (other VLAN) or DROP, then
// forwards it to the parser data stream (backpressured) or ctrl stream
// (no ready), or discards it. Keeps per-class packet counters.
// Ports:
//   axis_clk, aresetn        clock, asynchronous active-low reset
//   s_axis_*                 ingress stream (tready is backpressure)
//   m_axis_*                 data path to parser, with m_axis_tready
//   c_m_axis_*               ctrl path to parser, no ready
//   data/ctrl/drop_pkt_cnt   wrapping packet counters
// ---------------------------------------------------------------------------
module ingress_pkt_classifier
    import rmt_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              ctrl_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              drop_pkt_cnt
);

    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    clf_state_e state_q, state_d;
    pkt_class_e cls_q, idle_cls, get2_cls;

    logic [DW-1:0] h1_data_q, h2_data_q, emit_data;
    logic [UW-1:0] h1_user_q, h2_user_q, emit_user;
    logic [KW-1:0] h1_keep_q, h2_keep_q, emit_keep;
    logic          h1_last_q, h2_last_q, emit_last;

    logic [DW-1:0] c_data_q;
    logic [UW-1:0] c_user_q;
    logic [KW-1:0] c_keep_q;
    logic          c_valid_q, c_last_q;

    logic [CNT_WIDTH-1:0] data_cnt_q, ctrl_cnt_q, drop_cnt_q;

    logic accept, emit_ok, emit_fire, data_load, ctrl_load, drop_done;
    logic dout_can_load;

    // Classification: IDLE sees only beat 1 (1-beat packets), GET2 combines
    // the held beat 1 with the incoming beat 2.
    assign idle_cls = (be16(s_axis_tdata, OFS_ETHTYPE) == ETH_VLAN) ? CLS_DATA : CLS_DROP;

    always_comb begin
        get2_cls = CLS_DROP;
        if (be16(h1_data_q, OFS_ETHTYPE) == ETH_VLAN) begin
            get2_cls = CLS_DATA;
            if (be16(h1_data_q, OFS_INNER_ET) == ETH_IPV4 &&
                h1_data_q[8*OFS_PROTO +: 8] == IP_PROTO_UDP &&
                be16(s_axis_tdata, OFS_DPORT) == CTRL_UDP_PORT)
                get2_cls = CLS_CTRL;
        end
    end

    assign accept  = s_axis_tvalid && s_axis_tready;
    // Ctrl path has no backpressure; data path waits for the output register
    assign emit_ok = (cls_q == CLS_CTRL) || dout_can_load;

    // State register
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (accept) begin
                    if (!s_axis_tlast)              state_d = ST_GET2;
                    else if (idle_cls == CLS_DATA)  state_d = ST_EMIT1;
                end
            ST_GET2:
                if (accept) begin
                    if (get2_cls != CLS_DROP)       state_d = ST_EMIT1;
                    else if (s_axis_tlast)          state_d = ST_IDLE;
                    else                            state_d = ST_DROP;
                end
            ST_EMIT1:
                if (emit_ok) state_d = h1_last_q ? ST_IDLE : ST_EMIT2;
            ST_EMIT2:
                if (emit_ok) begin
                    if (h2_last_q)                  state_d = ST_IDLE;
                    else if (cls_q == CLS_CTRL)     state_d = ST_PASS_C;
                    else                            state_d = ST_PASS_D;
                end
            ST_PASS_D, ST_PASS_C, ST_DROP:
                if (accept && s_axis_tlast) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: ingress ready and the beat offered to the selected path
    always_comb begin
        logic rdy;
        rdy       = 1'b0;
        emit_fire = 1'b0;
        emit_data = h1_data_q;
        emit_user = h1_user_q;
        emit_keep = h1_keep_q;
        emit_last = h1_last_q;
        case (state_q)
            ST_IDLE, ST_GET2, ST_DROP: rdy = 1'b1;
            ST_EMIT1: emit_fire = emit_ok;
            ST_EMIT2: begin
                emit_fire = emit_ok;
                emit_data = h2_data_q;
                emit_user = h2_user_q;
                emit_keep = h2_keep_q;
                emit_last = h2_last_q;
            end
            ST_PASS_D, ST_PASS_C: begin
                rdy       = (state_q == ST_PASS_C) || dout_can_load;
                emit_fire = s_axis_tvalid && rdy;
                emit_data = s_axis_tdata;
                emit_user = s_axis_tuser;
                emit_keep = s_axis_tkeep;
                emit_last = s_axis_tlast;
            end
            default: rdy = 1'b0;
        endcase
        s_axis_tready = rdy && aresetn;
    end

    assign data_load = emit_fire && (cls_q == CLS_DATA);
    assign ctrl_load = emit_fire && (cls_q == CLS_CTRL);
    assign drop_done = accept && s_axis_tlast &&
                       ((state_q == ST_IDLE && idle_cls == CLS_DROP) ||
                        (state_q == ST_GET2 && get2_cls == CLS_DROP) ||
                        (state_q == ST_DROP));

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            cls_q      <= CLS_DROP;
            h1_data_q  <= '0;
            h1_user_q  <= '0;
            h1_keep_q  <= '0;
            h1_last_q  <= 1'b0;
            h2_data_q  <= '0;
            h2_user_q  <= '0;
            h2_keep_q  <= '0;
            h2_last_q  <= 1'b0;
            c_valid_q  <= 1'b0;
            c_data_q   <= '0;
            c_user_q   <= '0;
            c_keep_q   <= '0;
            c_last_q   <= 1'b0;
            data_cnt_q <= '0;
            ctrl_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE && accept) begin
                h1_data_q <= s_axis_tdata;
                h1_user_q <= s_axis_tuser;
                h1_keep_q <= s_axis_tkeep;
                h1_last_q <= s_axis_tlast;
                cls_q     <= idle_cls;
            end
            if (state_q == ST_GET2 && accept) begin
                h2_data_q <= s_axis_tdata;
                h2_user_q <= s_axis_tuser;
                h2_keep_q <= s_axis_tkeep;
                h2_last_q <= s_axis_tlast;
                cls_q     <= get2_cls;
            end
            c_valid_q <= ctrl_load;
            if (ctrl_load) begin
                c_data_q <= emit_data;
                c_user_q <= emit_user;
                c_keep_q <= emit_keep;
                c_last_q <= emit_last;
            end
            if (data_load && emit_last) data_cnt_q <= data_cnt_q + CNT_ONE;
            if (ctrl_load && emit_last) ctrl_cnt_q <= ctrl_cnt_q + CNT_ONE;
            if (drop_done)              drop_cnt_q <= drop_cnt_q + CNT_ONE;
        end
    end

    axis_out_reg #(
        .DATA_W (DW),
        .USER_W (UW)
    ) u_data_out (
        .clk_i      (axis_clk),
        .rst_ni     (aresetn),
        .load_i     (data_load),
        .data_i     (emit_data),
        .user_i     (emit_user),
        .keep_i     (emit_keep),
        .last_i     (emit_last),
        .ready_i    (m_axis_tready),
        .can_load_o (dout_can_load),
        .tdata_o    (m_axis_tdata),
        .tuser_o    (m_axis_tuser),
        .tkeep_o    (m_axis_tkeep),
        .tvalid_o   (m_axis_tvalid),
        .tlast_o    (m_axis_tlast)
    );

    assign c_m_axis_tdata  = c_data_q;
    assign c_m_axis_tuser  = c_user_q;
    assign c_m_axis_tkeep  = c_keep_q;
    assign c_m_axis_tvalid = c_valid_q;
    assign c_m_axis_tlast  = c_last_q;

    assign data_pkt_cnt = data_cnt_q;
    assign ctrl_pkt_cnt = ctrl_cnt_q;
    assign drop_pkt_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ingress_pkt_classifier.sv
// ---------------------------------------------------------------------------
// tb_ingress_pkt_classifier
// Directed bench: builds packets with known headers, queues the beats each
// path should carry, and checks outputs, backpressure and counters.
// ---------------------------------------------------------------------------
module tb_ingress_pkt_classifier;

    localparam int CLS_D = 0, CLS_C = 1, CLS_X = 2, CLS_NONE = 3;

    logic         axis_clk = 1'b0;
    logic         aresetn  = 1'b0;
    logic [255:0] s_axis_tdata = '0;
    logic [127:0] s_axis_tuser = '0;
    logic [31:0]  s_axis_tkeep = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast  = 1'b0;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [127:0] m_axis_tuser;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tvalid, m_axis_tlast;
    logic         m_axis_tready = 1'b1;
    logic [255:0] c_m_axis_tdata;
    logic [127:0] c_m_axis_tuser;
    logic [31:0]  c_m_axis_tkeep;
    logic         c_m_axis_tvalid, c_m_axis_tlast;
    logic [31:0]  data_pkt_cnt, ctrl_pkt_cnt, drop_pkt_cnt;

    always #5 axis_clk = ~axis_clk;

    ingress_pkt_classifier #(
        .C_S_AXIS_DATA_WIDTH  (256),
        .C_S_AXIS_TUSER_WIDTH (128),
        .CTRL_UDP_PORT        (16'hf1f2),
        .CNT_WIDTH            (32)
    ) dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .c_m_axis_tdata  (c_m_axis_tdata),
        .c_m_axis_tuser  (c_m_axis_tuser),
        .c_m_axis_tkeep  (c_m_axis_tkeep),
        .c_m_axis_tvalid (c_m_axis_tvalid),
        .c_m_axis_tlast  (c_m_axis_tlast),
        .data_pkt_cnt    (data_pkt_cnt),
        .ctrl_pkt_cnt    (ctrl_pkt_cnt),
        .drop_pkt_cnt    (drop_pkt_cnt)
    );

    typedef struct packed {
        logic [255:0] data;
        logic [127:0] user;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    beat_t exp_m_q[$];
    beat_t exp_c_q[$];
    beat_t mon_m, mon_c;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_data = 0, exp_ctrl = 0, exp_drop = 0;

    logic         tog_en   = 1'b0;
    logic [3:0]   tog_pat  = 4'b1001;   // index 0..3 -> ready 1,0,0,1
    int unsigned  tog_idx  = 0;
    logic         pass_chk = 1'b0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_data  = '0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: constant 1, or the 1,0,0,1 pattern while enabled
    always @(posedge axis_clk) begin
        #1;
        if (tog_en) begin
            m_axis_tready = tog_pat[tog_idx[1:0]];
            tog_idx++;
        end else begin
            m_axis_tready = 1'b1;
        end
    end

    // Output monitor / scoreboard
    always @(negedge axis_clk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check_eq("stall_hold", m_axis_tdata, prev_data);
            if (pass_chk && m_axis_tvalid && !m_axis_tready)
                check_eq("rdy_when_full", s_axis_tready, 0);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_m_q.size() == 0) begin
                    check_eq("m_unexpected", exp_m_q.size(), 1);
                end else begin
                    mon_m = exp_m_q.pop_front();
                    check_eq("m_data", m_axis_tdata, mon_m.data);
                    check_eq("m_side", {m_axis_tuser, m_axis_tkeep, m_axis_tlast},
                             {mon_m.user, mon_m.keep, mon_m.last});
                end
            end
            if (c_m_axis_tvalid) begin
                if (exp_c_q.size() == 0) begin
                    check_eq("c_unexpected", exp_c_q.size(), 1);
                end else begin
                    mon_c = exp_c_q.pop_front();
                    check_eq("c_data", c_m_axis_tdata, mon_c.data);
                    check_eq("c_side", {c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast},
                             {mon_c.user, mon_c.keep, mon_c.last});
                end
            end
        end
    end

    function automatic beat_t mk_beat(input int pid, input int b, input int nbeats,
                                      input logic [15:0] eth, input logic [15:0] inner,
                                      input logic [7:0] proto, input logic [15:0] dport);
        beat_t bt;
        for (int w = 0; w < 8; w++)
            bt.data[32*w +: 32] = {8'(pid), 8'(b), 8'hC0, 8'(w)};
        if (b == 0) begin
            bt.data[8*12 +: 8] = eth[15:8];
            bt.data[8*13 +: 8] = eth[7:0];
            bt.data[8*14 +: 8] = 8'h00;      // TCI: VID = 3
            bt.data[8*15 +: 8] = 8'h03;
            bt.data[8*16 +: 8] = inner[15:8];
            bt.data[8*17 +: 8] = inner[7:0];
            bt.data[8*27 +: 8] = proto;
        end
        if (b == 1) begin
            bt.data[8*8 +: 8] = dport[15:8];
            bt.data[8*9 +: 8] = dport[7:0];
        end
        bt.last = (b == nbeats - 1);
        bt.keep = bt.last ? 32'h0000_3fff : 32'hffff_ffff;
        bt.user = {8'(pid), 8'(b), 112'h5a5a_1234_0000_beef_cafe_0f0f_a5a5};
        return bt;
    endfunction

    task automatic send_beat(input beat_t bt, output int waited);
        logic ok;
        ok = 1'b0;
        waited = 0;
        s_axis_tdata  = bt.data;
        s_axis_tuser  = bt.user;
        s_axis_tkeep  = bt.keep;
        s_axis_tlast  = bt.last;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge axis_clk);
            ok = s_axis_tready;
            @(posedge axis_clk);
            if (!ok) waited++;
        end
        #1;
        s_axis_tvalid = 1'b0;
        if (!ok) check_eq("send_timeout", ok, 1);
    endtask

    task automatic send_range(input int pid, input int b_from, input int b_to, input int nbeats,
                              input logic [15:0] eth, input logic [15:0] inner,
                              input logic [7:0] proto, input logic [15:0] dport,
                              input int cls, input bit chk_nowait);
        beat_t bt;
        int    waited;
        for (int b = b_from; b <= b_to; b++) begin
            bt = mk_beat(pid, b, nbeats, eth, inner, proto, dport);
            if (cls == CLS_D) exp_m_q.push_back(bt);
            if (cls == CLS_C) exp_c_q.push_back(bt);
            pass_chk = (cls == CLS_D) && (b >= 2);
            send_beat(bt, waited);
            pass_chk = 1'b0;
            if (chk_nowait) check_eq("drop_tready", waited, 0);
        end
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge axis_clk);
            if (exp_m_q.size() == 0 && exp_c_q.size() == 0) break;
        end
        repeat (6) @(posedge axis_clk);
        #1;
        check_eq({tag, "_m_left"}, exp_m_q.size(), 0);
        check_eq({tag, "_c_left"}, exp_c_q.size(), 0);
        check_eq({tag, "_data_cnt"}, data_pkt_cnt, exp_data);
        check_eq({tag, "_ctrl_cnt"}, ctrl_pkt_cnt, exp_ctrl);
        check_eq({tag, "_drop_cnt"}, drop_pkt_cnt, exp_drop);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_s_tready"}, s_axis_tready, 0);
        check_eq({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check_eq({tag, "_c_tvalid"}, c_m_axis_tvalid, 0);
        check_eq({tag, "_data_cnt"}, data_pkt_cnt, 0);
        check_eq({tag, "_ctrl_cnt"}, ctrl_pkt_cnt, 0);
        check_eq({tag, "_drop_cnt"}, drop_pkt_cnt, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t bt;
        // Reset state
        aresetn = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        check_reset_outputs("rst");
        aresetn = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;

        // 1: VLAN IPv4 UDP dport 80, 4 beats -> data path
        send_range(1, 0, 3, 4, 16'h8100, 16'h0800, 8'h11, 16'h0050, CLS_D, 1'b0);
        exp_data++;
        drain_and_check("t1");

        // 2: VLAN IPv4 UDP ctrl port, 3 beats -> ctrl path
        send_range(2, 0, 2, 3, 16'h8100, 16'h0800, 8'h11, 16'hf1f2, CLS_C, 1'b0);
        exp_ctrl++;
        drain_and_check("t2");

        // 3: untagged IPv4, 5 beats -> dropped, never backpressured
        send_range(3, 0, 4, 5, 16'h0800, 16'h0006, 8'h11, 16'hf1f2, CLS_X, 1'b1);
        exp_drop++;
        drain_and_check("t3");

        // 4: data packet under 1,0,0,1 downstream ready
        tog_idx = 0;
        tog_en  = 1'b1;
        send_range(4, 0, 5, 6, 16'h8100, 16'h86dd, 8'h06, 16'h1234, CLS_D, 1'b0);
        exp_data++;
        drain_and_check("t4");
        tog_en = 1'b0;

        // 5: back-to-back 1-beat VLAN, ctrl, drop
        send_range(5, 0, 0, 1, 16'h8100, 16'h0800, 8'h11, 16'hf1f2, CLS_D, 1'b0);
        send_range(6, 0, 2, 3, 16'h8100, 16'h0800, 8'h11, 16'hf1f2, CLS_C, 1'b0);
        send_range(7, 0, 1, 2, 16'h88cc, 16'h0800, 8'h11, 16'hf1f2, CLS_X, 1'b0);
        exp_data++;
        exp_ctrl++;
        exp_drop++;
        drain_and_check("t5");

        // 6: reset while beat 3 of a 6-beat data packet is on the bus
        send_range(8, 0, 1, 6, 16'h8100, 16'h0800, 8'h11, 16'h0050, CLS_NONE, 1'b0);
        bt = mk_beat(8, 2, 6, 16'h8100, 16'h0800, 8'h11, 16'h0050);
        s_axis_tdata  = bt.data;
        s_axis_tuser  = bt.user;
        s_axis_tkeep  = bt.keep;
        s_axis_tlast  = bt.last;
        s_axis_tvalid = 1'b1;
        @(posedge axis_clk);
        #1;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        exp_m_q.delete();
        exp_c_q.delete();
        exp_data = 0;
        exp_ctrl = 0;
        exp_drop = 0;
        repeat (2) @(posedge axis_clk);
        #1;
        aresetn = 1'b1;
        @(posedge axis_clk);
        #1;
        // Remainder (beats 4..6) starts with a non-VLAN ethertype -> dropped
        send_range(8, 3, 5, 6, 16'h8100, 16'h0800, 8'h11, 16'h0050, CLS_X, 1'b0);
        exp_drop++;
        send_range(9, 0, 2, 3, 16'h8100, 16'h0800, 8'h11, 16'h0050, CLS_D, 1'b0);
        exp_data++;
        drain_and_check("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
